// File: rtl/iter_muldiv_unit_pkg.sv
// Opcode encodings and opcode-class helpers shared by the iterative multiply/divide unit.
package iter_muldiv_unit_pkg;

  localparam logic [3:0] OP_MULTS  = 4'd0;
  localparam logic [3:0] OP_MULTU  = 4'd1;
  localparam logic [3:0] OP_MULTFP = 4'd2;
  localparam logic [3:0] OP_DIVS   = 4'd3;
  localparam logic [3:0] OP_DIVU   = 4'd4;
  localparam logic [3:0] OP_DIVFP  = 4'd5;
  localparam logic [3:0] OP_MODS   = 4'd6;
  localparam logic [3:0] OP_MODU   = 4'd7;

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op == OP_MULTS) || (op == OP_MULTU) || (op == OP_MULTFP);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULTS) || (op == OP_MULTFP) || (op == OP_DIVS) ||
           (op == OP_DIVFP) || (op == OP_MODS);
  endfunction

  function automatic logic op_is_mod(input logic [3:0] op);
    return (op == OP_MODS) || (op == OP_MODU);
  endfunction

  function automatic logic op_is_valid(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/iter_muldiv_unit_muldiv_step.sv
// One combinational radix-2 step: shift/add for multiply, restoring subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mul_mode,
  input  logic [WIDTH-1:0]     hi,
  input  logic [2*WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]     opb,
  output logic [WIDTH-1:0]     hi_next,
  output logic [2*WIDTH-1:0]   lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    trial = {hi, lo[2*WIDTH-1]} - {1'b0, opb};
    if (mul_mode) begin
      // hi:lo[WIDTH-1:0] is the running product; multiplier bits shift out of lo[0]
      hi_next = sum[WIDTH:1];
      lo_next = {{WIDTH{1'b0}}, sum[0], lo[WIDTH-1:1]};
    end else begin
      // trial[WIDTH] set means the subtract borrowed: keep the shifted remainder
      hi_next = trial[WIDTH] ? {hi[WIDTH-2:0], lo[2*WIDTH-1]} : trial[WIDTH-1:0];
      lo_next = {lo[2*WIDTH-2:0], ~trial[WIDTH]};
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle MULT/DIV/MOD unit on one shared radix-2 datapath with start/done handshake.
// Optional last-result cache enabled by defining MULDIV_RESULT_CACHE_EN.
module iter_muldiv_unit
  import iter_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + FRAC) + 1;
  localparam logic [CW-1:0] CNT_INT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FP  = CW'(WIDTH + FRAC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIXUP} state_t;

  state_t               state;
  logic [3:0]           op_reg;
  logic [WIDTH-1:0]     a_reg, b_reg, opb_reg, acc_hi;
  logic [2*WIDTH-1:0]   acc_lo;
  logic [CW-1:0]        cnt;
  logic                 neg_reg, dz_reg;

  logic                 is_mul, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b, step_hi, quo_n, rem_n, fix_y;
  logic [2*WIDTH-1:0]   step_lo;
  logic [WIDTH+FRAC-1:0] prod, prod_n;

  assign is_mul = op_is_mul(op_reg);
  assign a_neg  = op_is_signed(op_reg) & a_reg[WIDTH-1];
  assign b_neg  = op_is_signed(op_reg) & b_reg[WIDTH-1];
  assign mag_a  = a_neg ? -a_reg : a_reg;
  assign mag_b  = b_neg ? -b_reg : b_reg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mul_mode (is_mul),
    .hi       (acc_hi),
    .lo       (acc_lo),
    .opb      (opb_reg),
    .hi_next  (step_hi),
    .lo_next  (step_lo)
  );

  // The last radix-2 step is taken combinationally in FIXUP, so ITER runs one cycle short.
  assign prod   = {step_hi[FRAC-1:0], step_lo[WIDTH-1:0]};
  assign prod_n = neg_reg ? -prod : prod;
  assign quo_n  = neg_reg ? -step_lo[WIDTH-1:0] : step_lo[WIDTH-1:0];
  assign rem_n  = neg_reg ? -step_hi : step_hi;

  always_comb begin
    fix_y = rem_n;
    case (op_reg)
      OP_MULTS, OP_MULTU:         fix_y = prod_n[WIDTH-1:0];
      OP_MULTFP:                  fix_y = prod_n[WIDTH+FRAC-1:FRAC];
      OP_DIVS, OP_DIVU, OP_DIVFP: fix_y = quo_n;
      default:                    fix_y = rem_n;
    endcase
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic             cache_valid;
  logic [3:0]       cache_op;
  logic [WIDTH-1:0] cache_a, cache_b;
  logic             cache_hit;
  // y/dbz already hold the cached result since they only change on done
  assign cache_hit = cache_valid && (opcode == cache_op) && (a == cache_a) && (b == cache_b);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= '0;
      dbz     <= 1'b0;
      op_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      opb_reg <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      neg_reg <= 1'b0;
      dz_reg  <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
      cache_valid <= 1'b0;
      cache_op    <= '0;
      cache_a     <= '0;
      cache_b     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
        cache_valid <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_reg <= opcode;
              a_reg  <= a;
              b_reg  <= b;
`ifdef MULDIV_RESULT_CACHE_EN
              if (cache_hit) begin
                done <= 1'b1;
              end else begin
                state <= LOAD;
                busy  <= 1'b1;
              end
`else
              state <= LOAD;
              busy  <= 1'b1;
`endif
            end
          end
          LOAD: begin
            neg_reg <= op_is_mod(op_reg) ? a_neg : (a_neg ^ b_neg);
            dz_reg  <= 1'b0;
            if (!op_is_valid(op_reg)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              y     <= '0;
              dbz   <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
              cache_valid <= 1'b1;
              cache_op    <= op_reg;
              cache_a     <= a_reg;
              cache_b     <= b_reg;
`endif
            end else if (!is_mul && (b_reg == '0)) begin
              dz_reg <= 1'b1;
              state  <= FIXUP;
            end else begin
              acc_hi <= '0;
              if (is_mul) begin
                acc_lo  <= {{WIDTH{1'b0}}, mag_b};
                opb_reg <= mag_a;
              end else begin
                // Left-aligned dividend; DIVFP just runs FRAC extra steps to realise a<<FRAC
                acc_lo  <= {mag_a, {WIDTH{1'b0}}};
                opb_reg <= mag_b;
              end
              cnt   <= (op_reg == OP_DIVFP) ? CNT_FP : CNT_INT;
              state <= ITER;
            end
          end
          ITER: begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= FIXUP;
          end
          FIXUP: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (dz_reg) begin
              y   <= op_is_mod(op_reg) ? a_reg : '1;
              dbz <= 1'b1;
            end else begin
              y   <= fix_y;
              dbz <= 1'b0;
            end
`ifdef MULDIV_RESULT_CACHE_EN
            cache_valid <= 1'b1;
            cache_op    <= op_reg;
            cache_a     <= a_reg;
            cache_b     <= b_reg;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
